// File: rtl/read_compare_block.sv
// Read-data checker: queues compare packets, regenerates the expected pattern per beat and flags the first error.
// Optional build macro CMP_ERR_CNT_EN: keep checking after data mismatches and count mismatching beats.
module read_compare_block #(
  parameter int AMM_DATA_W     = 128,
  parameter int BYTE_PER_WORD  = AMM_DATA_W / 8,
  parameter int ADDR_W         = 28,
  parameter int AMM_BURST_W    = 11,
  parameter int PKT_FIFO_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     test_start_i,
  input  logic                     cmp_pkt_en_i,
  output logic                     cmp_pkt_ready_o,
  input  logic [ADDR_W-1:0]        cmp_word_addr_i,
  input  logic [AMM_BURST_W-1:0]   cmp_burst_cnt_i,
  input  logic [BYTE_PER_WORD-1:0] cmp_start_mask_i,
  input  logic [BYTE_PER_WORD-1:0] cmp_end_mask_i,
  input  logic                     cmp_ptrn_type_i,
  input  logic [7:0]               cmp_ptrn_i,
  input  logic                     readdatavalid_i,
  input  logic [AMM_DATA_W-1:0]    readdata_i,
  output logic                     error_check_o,
  output logic [ADDR_W-1:0]        err_addr_o,
  output logic [AMM_DATA_W-1:0]    err_data_o,
  output logic [BYTE_PER_WORD-1:0] err_byte_o,
  output logic                     err_proto_o,
  output logic [31:0]              words_checked_o,
  output logic [15:0]              err_cnt_o
);

  localparam int PTR_W = $clog2(PKT_FIFO_DEPTH);
  localparam int CNT_W = $clog2(PKT_FIFO_DEPTH + 1);
  localparam int PKT_W = ADDR_W + AMM_BURST_W + 2 * BYTE_PER_WORD + 9;

  typedef enum logic [1:0] {IDLE, CHECK, ERR} state_t;

  state_t                   state;
  logic [PKT_W-1:0]         fifo_mem [PKT_FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         fifo_cnt, cnt_nxt;
  logic [PKT_W-1:0]         pkt_in;
  logic [ADDR_W-1:0]        hd_addr, act_addr, beat_addr;
  logic [AMM_BURST_W-1:0]   hd_burst, act_burst, idx;
  logic [BYTE_PER_WORD-1:0] hd_smask, hd_emask, act_smask, act_emask;
  logic                     hd_ptype, act_ptype;
  logic [7:0]               hd_ptrn, act_ptrn, lfsr, exp_byte;

  logic                     s1_valid, s2_valid;
  logic [AMM_DATA_W-1:0]    s1_data, s1_exp, s2_data;
  logic [BYTE_PER_WORD-1:0] s1_mask, s2_miss, miss_c, beat_mask;
  logic [ADDR_W-1:0]        s1_addr, s2_addr;

  logic fifo_empty, fifo_full, beat, last_beat, live;
  logic data_err, data_stop, pop_base, orphan, overflow;
  logic proto_err, go_err, pop, push, accept;

  assign pkt_in = {cmp_word_addr_i, cmp_burst_cnt_i, cmp_start_mask_i,
                   cmp_end_mask_i, cmp_ptrn_type_i, cmp_ptrn_i};
  assign {hd_addr, hd_burst, hd_smask, hd_emask, hd_ptype, hd_ptrn} = fifo_mem[rd_ptr];

  always_comb begin
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == CNT_W'(PKT_FIFO_DEPTH));
    beat       = readdatavalid_i && !test_start_i;
    last_beat  = (idx == act_burst);
    live       = !test_start_i && (state != ERR);
    data_err   = s2_valid && (|s2_miss);
`ifdef CMP_ERR_CNT_EN
    data_stop  = 1'b0;
`else
    data_stop  = data_err;
`endif
    // Overflow must see the pop candidate, not the final pop, to avoid a combinational loop.
    pop_base   = live && !fifo_empty && !data_stop &&
                 ((state == IDLE) || ((state == CHECK) && beat && last_beat));
    orphan     = live && beat && (state == IDLE);
    overflow   = live && cmp_pkt_en_i && fifo_full && !pop_base;
    proto_err  = orphan || overflow;
    go_err     = proto_err || (live && data_stop);
    pop        = pop_base && !proto_err;
    push       = live && !go_err && cmp_pkt_en_i && (!fifo_full || pop);
    accept     = live && !go_err && beat && (state == CHECK);
    cnt_nxt    = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

    if (act_burst == '0)   beat_mask = act_smask & act_emask;
    else if (idx == '0)    beat_mask = act_smask;
    else if (last_beat)    beat_mask = act_emask;
    else                   beat_mask = '1;
    exp_byte  = act_ptype ? lfsr : act_ptrn;
    beat_addr = act_addr + ADDR_W'(idx);

    miss_c = '0;
    for (int unsigned b = 0; b < BYTE_PER_WORD; b++)
      miss_c[b] = s1_mask[b] && (s1_data[8*b +: 8] != s1_exp[8*b +: 8]);
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= pkt_in;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      cmp_pkt_ready_o <= 1'b1;
      act_addr        <= '0;
      act_burst       <= '0;
      act_smask       <= '0;
      act_emask       <= '0;
      act_ptype       <= 1'b0;
      act_ptrn        <= '0;
      idx             <= '0;
      lfsr            <= '0;
      s1_valid        <= 1'b0;
      s1_data         <= '0;
      s1_exp          <= '0;
      s1_mask         <= '0;
      s1_addr         <= '0;
      s2_valid        <= 1'b0;
      s2_miss         <= '0;
      s2_data         <= '0;
      s2_addr         <= '0;
      error_check_o   <= 1'b0;
      err_addr_o      <= '0;
      err_data_o      <= '0;
      err_byte_o      <= '0;
      err_proto_o     <= 1'b0;
      words_checked_o <= '0;
`ifdef CMP_ERR_CNT_EN
      err_cnt_o       <= '0;
`endif
    end else if (test_start_i) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      cmp_pkt_ready_o <= 1'b1;
      idx             <= '0;
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
      s2_miss         <= '0;
      error_check_o   <= 1'b0;
      err_addr_o      <= '0;
      err_data_o      <= '0;
      err_byte_o      <= '0;
      err_proto_o     <= 1'b0;
      words_checked_o <= '0;
`ifdef CMP_ERR_CNT_EN
      err_cnt_o       <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt        <= cnt_nxt;
      cmp_pkt_ready_o <= !go_err && (state != ERR) && (cnt_nxt != CNT_W'(PKT_FIFO_DEPTH));

      if (go_err) state <= ERR;
      else if (state == IDLE && pop) state <= CHECK;
      else if (state == CHECK && accept && last_beat && !pop) state <= IDLE;

      // A pop on the last beat reloads the active slot so the next burst starts with no bubble.
      if (pop) begin
        act_addr  <= hd_addr;
        act_burst <= hd_burst;
        act_smask <= hd_smask;
        act_emask <= hd_emask;
        act_ptype <= hd_ptype;
        act_ptrn  <= hd_ptrn;
        idx       <= '0;
        lfsr      <= hd_ptrn;
      end else if (accept) begin
        idx  <= idx + AMM_BURST_W'(1);
        lfsr <= {lfsr[6:0], lfsr[6] ^ lfsr[1] ^ lfsr[0]};
      end

      s1_valid <= accept;
      if (accept) begin
        s1_data <= readdata_i;
        s1_exp  <= {BYTE_PER_WORD{exp_byte}};
        s1_mask <= beat_mask;
        s1_addr <= beat_addr;
      end
      s2_valid <= s1_valid;
      s2_miss  <= miss_c;
      s2_data  <= s1_data;
      s2_addr  <= s1_addr;

      if (accept && words_checked_o != '1)
        words_checked_o <= words_checked_o + 32'd1;

      if (data_err) begin
        error_check_o <= 1'b1;
        if (!error_check_o) begin
          err_addr_o  <= s2_addr;
          err_data_o  <= s2_data;
          err_byte_o  <= s2_miss;
          err_proto_o <= 1'b0;
        end
`ifdef CMP_ERR_CNT_EN
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
`endif
      end else if (proto_err) begin
        error_check_o <= 1'b1;
        if (!error_check_o) begin
          err_addr_o  <= '0;
          err_data_o  <= orphan ? readdata_i : '0;
          err_byte_o  <= '0;
          err_proto_o <= 1'b1;
        end
      end
    end
  end

`ifndef CMP_ERR_CNT_EN
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_read_compare_block.sv
// Scoreboard bench for read_compare_block: expected errors are queued by stimulus and matched by a monitor.
module tb_read_compare_block;
  localparam int DW  = 128;
  localparam int BW  = DW / 8;
  localparam int AW  = 28;
  localparam int BUW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          test_start = 1'b0;
  logic          cmp_pkt_en = 1'b0;
  logic          cmp_pkt_ready;
  logic [AW-1:0] cmp_word_addr = '0;
  logic [BUW-1:0] cmp_burst_cnt = '0;
  logic [BW-1:0] cmp_start_mask = '0;
  logic [BW-1:0] cmp_end_mask = '0;
  logic          cmp_ptrn_type = 1'b0;
  logic [7:0]    cmp_ptrn = '0;
  logic          rdv = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          error_check;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;
  logic [BW-1:0] err_byte;
  logic          err_proto;
  logic [31:0]   words_checked;
  logic [15:0]   err_cnt;

  always #5 clk = ~clk;

  read_compare_block #(
    .AMM_DATA_W(DW), .BYTE_PER_WORD(BW), .ADDR_W(AW), .AMM_BURST_W(BUW), .PKT_FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .test_start_i(test_start),
    .cmp_pkt_en_i(cmp_pkt_en), .cmp_pkt_ready_o(cmp_pkt_ready),
    .cmp_word_addr_i(cmp_word_addr), .cmp_burst_cnt_i(cmp_burst_cnt),
    .cmp_start_mask_i(cmp_start_mask), .cmp_end_mask_i(cmp_end_mask),
    .cmp_ptrn_type_i(cmp_ptrn_type), .cmp_ptrn_i(cmp_ptrn),
    .readdatavalid_i(rdv), .readdata_i(rdata),
    .error_check_o(error_check), .err_addr_o(err_addr), .err_data_o(err_data),
    .err_byte_o(err_byte), .err_proto_o(err_proto),
    .words_checked_o(words_checked), .err_cnt_o(err_cnt)
  );

  typedef struct {
    string         name;
    int            rise;
    logic [AW-1:0] addr;
    logic [BW-1:0] bmap;
    logic          proto;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic err_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising error_check_o must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && error_check && !err_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_err: got error_check_o=1 expected 0 at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.rise >= 0) chk({mon_e.name, "_latency"}, DW'(cyc), DW'(mon_e.rise));
        chk({mon_e.name, "_proto"}, DW'(err_proto), DW'(mon_e.proto));
        chk({mon_e.name, "_byte"}, DW'(err_byte), DW'(mon_e.bmap));
        if (!mon_e.proto) chk({mon_e.name, "_addr"}, DW'(err_addr), DW'(mon_e.addr));
      end
    end
    err_prev = error_check;
  end

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {BW{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [AW-1:0] a, input logic [BUW-1:0] bc, input logic [BW-1:0] sm,
                          input logic [BW-1:0] em, input logic pt, input logic [7:0] p);
    cmp_word_addr = a; cmp_burst_cnt = bc; cmp_start_mask = sm;
    cmp_end_mask = em; cmp_ptrn_type = pt; cmp_ptrn = p;
    cmp_pkt_en = 1'b1;
    tick();
    cmp_pkt_en = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    rdv = 1'b1;
    rdata = d;
    tick();
    rdv = 1'b0;
  endtask

  task automatic expect_err(input string n, input int rise, input logic [AW-1:0] a,
                            input logic [BW-1:0] bm, input logic pr);
    exp_t e;
    e.name = n; e.rise = rise; e.addr = a; e.bmap = bm; e.proto = pr;
    exp_q.push_back(e);
  endtask

  // Beat sampled at edge cyc+1; error visible after two further edges.
  task automatic beat_bad(input string n, input logic [DW-1:0] d, input logic [AW-1:0] a,
                          input logic [BW-1:0] bm);
    expect_err(n, cyc + 3, a, bm, 1'b0);
    beat(d);
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk({n, "_drained"}, DW'(exp_q.size()), '0);
  endtask

  task automatic start_test();
    test_start = 1'b1;
    tick();
    test_start = 1'b0;
  endtask

  task automatic check_clear(input string n);
    chk({n, "_err"}, DW'(error_check), '0);
    chk({n, "_ready"}, DW'(cmp_pkt_ready), DW'(1));
    chk({n, "_words"}, DW'(words_checked), '0);
    chk({n, "_eaddr"}, DW'(err_addr), '0);
    chk({n, "_edata"}, err_data, '0);
    chk({n, "_ebyte"}, DW'(err_byte), '0);
    chk({n, "_eproto"}, DW'(err_proto), '0);
    chk({n, "_ecnt"}, DW'(err_cnt), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    repeat (2) @(posedge clk);
    #1;
    check_clear("reset");
    rst_n = 1'b1;
    tick();

    // Fixed pattern, 4-beat burst, all bytes enabled.
    push_pkt(28'h100, 11'd3, '1, '1, 1'b0, 8'hA5);
    tick();
    repeat (4) beat(fill(8'hA5));
    repeat (3) tick();
    chk("fixed_words", DW'(words_checked), DW'(4));
    chk("fixed_noerr", DW'(error_check), '0);
    chk("fixed_ready", DW'(cmp_pkt_ready), DW'(1));

    // LFSR seed 01: 01, 03, 06, 0D.
    push_pkt(28'h200, 11'd3, '1, '1, 1'b1, 8'h01);
    tick();
    beat(fill(8'h01)); beat(fill(8'h03)); beat(fill(8'h06)); beat(fill(8'h0D));
    repeat (3) tick();
    chk("lfsr_words", DW'(words_checked), DW'(8));
    chk("lfsr_noerr", DW'(error_check), '0);

    // Single beat: effective mask FFF0 & 00FF = bytes 4..7.
    push_pkt(28'h300, 11'd0, 16'hFFF0, 16'h00FF, 1'b0, 8'h5A);
    tick();
    d = fill(8'h33);
    for (int b = 4; b < 8; b++) d[8*b +: 8] = 8'h5A;
    beat(d);
    repeat (3) tick();
    chk("single_words", DW'(words_checked), DW'(9));
    chk("single_noerr", DW'(error_check), '0);

    // 3 beats: start mask on beat 0, all on beat 1, end mask on beat 2.
    push_pkt(28'h310, 11'd2, 16'h000F, 16'hF000, 1'b0, 8'h3C);
    tick();
    d = fill(8'hC3);
    for (int b = 0; b < 4; b++) d[8*b +: 8] = 8'h3C;
    beat(d);
    beat(fill(8'h3C));
    d = fill(8'hC3);
    for (int b = 12; b < 16; b++) d[8*b +: 8] = 8'h3C;
    beat(d);
    repeat (3) tick();
    chk("mask_words", DW'(words_checked), DW'(12));
    chk("mask_noerr", DW'(error_check), '0);

    // Seed FF stays FF under the feedback taps; byte 2 of beat 1 corrupted.
    push_pkt(28'h400, 11'd1, '1, '1, 1'b1, 8'hFF);
    tick();
    beat(fill(8'hFF));
    d = fill(8'hFF);
    d[23:16] = 8'h00;
    beat_bad("lfsr_err", d, 28'h401, 16'h0004);
    drain("lfsr_err");
    chk("lfsr_err_data", err_data, d);
    chk("lfsr_err_words", DW'(words_checked), DW'(14));
`ifndef CMP_ERR_CNT_EN
    chk("err_state_ready", DW'(cmp_pkt_ready), '0);
    chk("err_cnt_tied", DW'(err_cnt), '0);
`endif
    push_pkt(28'h480, 11'd0, '1, '1, 1'b0, 8'h00);
    start_test();
    check_clear("clear1");

    // Address wrap: base FFFFFFF, bad beat lands on 0.
    push_pkt(28'hFFF_FFFF, 11'd1, '1, '1, 1'b0, 8'h11);
    tick();
    beat(fill(8'h11));
    d = fill(8'h11);
    d[127:120] = 8'hEE;
    beat_bad("wrap_err", d, 28'h000_0000, 16'h8000);
    drain("wrap_err");
    start_test();

    // Orphan beat with empty queue.
    expect_err("orphan", -1, '0, '0, 1'b1);
    beat(fill(8'h99));
    drain("orphan");
    chk("orphan_proto", DW'(err_proto), DW'(1));
    chk("orphan_ready", DW'(cmp_pkt_ready), '0);
    start_test();
    check_clear("clear2");

    // Fill: first packet moves to the active slot, the next four fill the queue.
    for (int k = 0; k < 5; k++) begin
      push_pkt(28'h500 + AW'(k), 11'd0, '1, '1, 1'b0, 8'h77);
      chk($sformatf("fill_ready_%0d", k), DW'(cmp_pkt_ready), DW'(k < 4));
    end
    // Last beat pops while a push arrives on a full queue: accepted, no overflow.
    cmp_word_addr = 28'h505; cmp_burst_cnt = '0; cmp_start_mask = '1;
    cmp_end_mask = '1; cmp_ptrn_type = 1'b0; cmp_ptrn = 8'h77;
    cmp_pkt_en = 1'b1;
    rdv = 1'b1;
    rdata = fill(8'h77);
    tick();
    cmp_pkt_en = 1'b0;
    rdv = 1'b0;
    repeat (3) tick();
    chk("pushpop_noerr", DW'(error_check), '0);
    chk("pushpop_ready", DW'(cmp_pkt_ready), '0);
    chk("pushpop_words", DW'(words_checked), DW'(1));
    expect_err("overflow", -1, '0, '0, 1'b1);
    push_pkt(28'h506, 11'd0, '1, '1, 1'b0, 8'h77);
    drain("overflow");
    chk("overflow_proto", DW'(err_proto), DW'(1));
    start_test();
    check_clear("clear3");

`ifdef CMP_ERR_CNT_EN
    // Counting mode: beats 2, 4, 5 corrupted in an 8-beat burst.
    push_pkt(28'h600, 11'd7, '1, '1, 1'b0, 8'hC3);
    tick();
    d = fill(8'hC3);
    d[7:0] = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) beat_bad("cnt_err", d, 28'h602, 16'h0001);
      else if (k == 4 || k == 5) beat(d);
      else beat(fill(8'hC3));
    end
    drain("cnt_err");
    repeat (3) tick();
    chk("cnt_value", DW'(err_cnt), DW'(3));
    chk("cnt_words", DW'(words_checked), DW'(8));
    chk("cnt_addr", DW'(err_addr), DW'(28'h602));
    chk("cnt_sticky", DW'(error_check), DW'(1));
`endif

    repeat (4) tick();
    chk("final_queue", DW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
